// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add Q-format multiplier: default widths,
// FSM encoding and the Q1.15 saturation limits.
package shift_add_mult_pkg;

  localparam int unsigned WORDLENGTH_DEF = 16;
  localparam int unsigned FRACBITS_DEF   = 15;

  localparam logic [WORDLENGTH_DEF-1:0] MAXPOS = {1'b0, {(WORDLENGTH_DEF-1){1'b1}}};
  localparam logic [WORDLENGTH_DEF-1:0] MAXNEG = {1'b1, {(WORDLENGTH_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFinish
  } state_e;

endpackage

// File: rtl/shift_add_mult_round_sat.sv
// Combinational round-half-away-from-zero, sign application and saturation of the
// unsigned 2*WORDLENGTH+1-bit product magnitude.
module round_sat
  import shift_add_mult_pkg::*;
#(
  parameter int unsigned WORDLENGTH = WORDLENGTH_DEF,
  parameter int unsigned FRACBITS   = FRACBITS_DEF
) (
  input  logic                    sign,
  input  logic [2*WORDLENGTH:0]   mag,
  output logic [WORDLENGTH-1:0]   product
);

  localparam logic [2*WORDLENGTH:0] Half   = {{(2*WORDLENGTH){1'b0}}, 1'b1} << (FRACBITS - 1);
  localparam logic [2*WORDLENGTH:0] PosLim = {{(WORDLENGTH+2){1'b0}}, {(WORDLENGTH-1){1'b1}}};
  localparam logic [2*WORDLENGTH:0] NegLim =
      {{(WORDLENGTH+1){1'b0}}, 1'b1, {(WORDLENGTH-1){1'b0}}};

  logic [2*WORDLENGTH:0] rounded;
  logic [WORDLENGTH-1:0] sat_pos, sat_neg;

  if (WORDLENGTH == WORDLENGTH_DEF) begin : g_pkg_sat
    assign sat_pos = MAXPOS;
    assign sat_neg = MAXNEG;
  end else begin : g_gen_sat
    assign sat_pos = {1'b0, {(WORDLENGTH-1){1'b1}}};
    assign sat_neg = {1'b1, {(WORDLENGTH-1){1'b0}}};
  end

  assign rounded = (mag + Half) >> FRACBITS;

  // Negative side may reach exactly 2^(W-1) before saturating; its negation is MAXNEG.
  always_comb begin
    product = '0;
    if (!sign) begin
      product = (rounded > PosLim) ? sat_pos : rounded[WORDLENGTH-1:0];
    end else begin
      product = (rounded > NegLim) ? sat_neg : -rounded[WORDLENGTH-1:0];
    end
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential signed Q-format multiplier: one magnitude bit of the multiplier per
// cycle, then a rounding/saturation cycle. Fixed latency of WORDLENGTH+1 cycles.
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int unsigned WORDLENGTH = WORDLENGTH_DEF,
  parameter int unsigned FRACBITS   = FRACBITS_DEF
) (
  input  logic                  clk30x,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORDLENGTH-1:0] multiplicand,
  input  logic [WORDLENGTH-1:0] multiplier,
  output logic [WORDLENGTH-1:0] product,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntW = (WORDLENGTH > 1) ? $clog2(WORDLENGTH) : 1;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [2*WORDLENGTH:0] mcand_q, acc_q, addend, sum;
  logic [WORDLENGTH:0]   mplier_q;
  logic                  sign_q, busy_q, done_q;
  logic [WORDLENGTH-1:0] product_q, rs_product;
  logic [WORDLENGTH:0]   a_ext, b_ext, mag_a, mag_b;
  logic                  last;

  assign a_ext = {multiplicand[WORDLENGTH-1], multiplicand};
  assign b_ext = {multiplier[WORDLENGTH-1], multiplier};
  assign mag_a = a_ext[WORDLENGTH] ? -a_ext : a_ext;
  assign mag_b = b_ext[WORDLENGTH] ? -b_ext : b_ext;
  assign last  = (cnt_q == CntW'(WORDLENGTH - 1));

  // On the last pass the top magnitude bit (only ever set alone) shares the single adder.
  always_comb begin
    addend = '0;
    if (mplier_q[0]) begin
      addend = mcand_q;
    end else if (last && mplier_q[1]) begin
      addend = mcand_q << 1;
    end
  end

  assign sum = acc_q + addend;

  round_sat #(
    .WORDLENGTH(WORDLENGTH),
    .FRACBITS  (FRACBITS)
  ) u_round_sat (
    .sign   (sign_q),
    .mag    (acc_q),
    .product(rs_product)
  );

  always_ff @(posedge clk30x or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      sign_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q  <= {{WORDLENGTH{1'b0}}, mag_a};
            mplier_q <= mag_b;
            sign_q   <= multiplicand[WORDLENGTH-1] ^ multiplier[WORDLENGTH-1];
            cnt_q    <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_q    <= sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          if (last) begin
            state_q <= StFinish;
          end
        end
        StFinish: begin
          product_q <= rs_product;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed-vector and random self-checking bench for shift_add_mult at default widths.
module tb_shift_add_mult;
  import shift_add_mult_pkg::*;

  logic        clk30x = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] multiplicand = '0;
  logic [15:0] multiplier = '0;
  logic [15:0] product;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  shift_add_mult dut (
    .clk30x      (clk30x),
    .reset       (reset),
    .start       (start),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .product     (product),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk30x = ~clk30x;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
    longint pa, pb, mag, rnd;
    logic   neg;
    pa  = longint'($signed(a));
    pb  = longint'($signed(b));
    mag = pa * pb;
    if (mag < 0) mag = -mag;
    rnd = (mag + 16384) >>> 15;
    neg = a[15] ^ b[15];
    if (!neg) return (rnd > 32767) ? 16'h7FFF : 16'(rnd);
    return (rnd > 32768) ? 16'h8000 : 16'(-rnd);
  endfunction

  // Starts one operation (sampled on the next edge) and waits for done with a bound.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp,
                        input string name, input bit full);
    int lat;
    @(negedge clk30x);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk30x);
    #1;
    start        = 1'b0;
    multiplicand = 16'hDEAD;
    multiplier   = 16'hBEEF;
    if (full) check({name, " busy_set"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk30x);
      #1;
      lat++;
    end
    if (full || lat != 17) check({name, " latency"}, lat, 17);
    check({name, " product"}, 32'(product), 32'(exp));
    if (full) check({name, " busy_clr"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  ndone;
    int  lat;
    logic [15:0] ra, rb;

    vecs[0]  = '{16'h4000, 16'h4000, 16'h2000, "half_sq"};
    vecs[1]  = '{16'h8000, 16'h8000, MAXPOS,   "neg1_sq_sat"};
    vecs[2]  = '{16'h8000, 16'h7FFF, 16'h8001, "neg1_x_max"};
    vecs[3]  = '{16'h0001, 16'h4000, 16'h0001, "half_up_pos"};
    vecs[4]  = '{16'hFFFF, 16'h4000, 16'hFFFF, "half_up_neg"};
    vecs[5]  = '{16'h7FFF, 16'h7FFF, 16'h7FFE, "max_sq"};
    vecs[6]  = '{16'h8000, 16'h0001, 16'hFFFF, "neg1_x_lsb"};
    vecs[7]  = '{16'h0000, 16'h8000, 16'h0000, "zero_x_neg1"};
    vecs[8]  = '{16'h4000, 16'hC000, 16'hE000, "half_x_neghalf"};
    vecs[9]  = '{16'hFFFF, 16'hFFFF, 16'h0000, "tiny_rounds_zero"};
    vecs[10] = '{16'h8000, 16'hC000, 16'h4000, "neg1_x_neghalf"};
    vecs[11] = '{16'h1234, 16'h5678, 16'h0C4C, "mixed"};

    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", 32'(product), 32'd0);
    @(negedge clk30x);
    reset = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, 1'b1);

    // Starts during RUN and FINISH must be ignored; the next idle edge accepts.
    @(negedge clk30x);
    multiplicand = 16'h4000;
    multiplier   = 16'h4000;
    start        = 1'b1;
    @(posedge clk30x);
    ndone = 0;
    for (int e = 1; e <= 17; e++) begin
      @(negedge clk30x);
      start        = (e == 5 || e == 17);
      multiplicand = 16'h7FFF;
      multiplier   = 16'h7FFF;
      @(posedge clk30x);
      #1;
      if (done) ndone++;
      if (e == 16) check("ignore done_not_early", 32'(done), 32'd0);
      if (e == 17) check("ignore done_edge17", 32'(done), 32'd1);
    end
    check("ignore done_count", ndone, 1);
    check("ignore product", 32'(product), 32'h2000);
    @(negedge clk30x);
    multiplicand = 16'h2000;
    multiplier   = 16'h4000;
    start        = 1'b1;
    @(posedge clk30x);
    #1;
    start = 1'b0;
    check("edge18 accepted", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk30x);
      #1;
      lat++;
    end
    check("edge18 latency", lat, 17);
    check("edge18 product", 32'(product), 32'h1000);

    // Mid-run asynchronous reset aborts without a done pulse.
    @(negedge clk30x);
    multiplicand = 16'h4000;
    multiplier   = 16'h4000;
    start        = 1'b1;
    @(posedge clk30x);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk30x);
    #2;
    reset = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort product", 32'(product), 32'd0);
    repeat (2) @(posedge clk30x);
    @(negedge clk30x);
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk30x);
      #1;
      if (done) ndone++;
    end
    check("abort no_done", ndone, 0);

    // Start on the very first edge after release.
    @(negedge clk30x);
    reset        = 1'b0;
    @(negedge clk30x);
    multiplicand = 16'h6000;
    multiplier   = 16'h4000;
    start        = 1'b1;
    reset        = 1'b1;
    @(posedge clk30x);
    #1;
    start = 1'b0;
    check("post_reset accepted", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk30x);
      #1;
      lat++;
    end
    check("post_reset latency", lat, 17);
    check("post_reset product", 32'(product), 32'h3000);

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, ref_mult(ra, rb), $sformatf("rand%0d %h*%h", n, ra, rb), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter WORDLENGTH, default 16, operand and product width in bits.
REQ-002 Parameter FRACBITS, default 15, fractional bits of the Q format (Q1.15 at defaults).
REQ-003 clk30x  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; logic 0 clears all state immediately.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 multiplicand  input  WORDLENGTH  signed two's-complement operand A.
REQ-007 multiplier  input  WORDLENGTH  signed two's-complement operand B.
REQ-008 product  output  WORDLENGTH  signed rounded, saturated A*B in Q format; registered.
REQ-009 busy  output  1  high while a multiplication is in progress; registered.
REQ-010 done  output  1  one-cycle pulse when product updates; registered.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and FINISH.
REQ-012 In IDLE with start=1 at edge k, operands SHALL be latched, |A| and |B| formed as unsigned WORDLENGTH+1-bit magnitudes, result sign = sign(A) XOR sign(B), bit counter cleared, accumulator cleared, busy set, and state -> RUN.
REQ-013 In RUN, each edge SHALL process one magnitude bit of B, LSB first: accumulator += (|A| << i) when bit i is 1; counter increments.
REQ-014 RUN SHALL last exactly WORDLENGTH edges (k+1 .. k+WORDLENGTH); then state -> FINISH.
REQ-015 Bit WORDLENGTH of |B| is set only for B = most-negative; it SHALL be handled in the same pass (no extra cycle).
REQ-016 At edge k+WORDLENGTH+1 (FINISH -> IDLE), product SHALL be loaded, done=1 for exactly that cycle, busy=0.
REQ-017 Latency start-sample to done SHALL be WORDLENGTH+1 cycles (17 at defaults), constant for all operands.
REQ-018 Rounding SHALL be round-half-away-from-zero: add 2^(FRACBITS-1) to the 2*WORDLENGTH+1-bit magnitude, shift right by FRACBITS, then apply sign.
REQ-019 A positive result above 2^(WORDLENGTH-1)-1 SHALL saturate to 0x7FFF; a negative result below -2^(WORDLENGTH-1) SHALL saturate to 0x8000.
REQ-020 A rounded magnitude of zero SHALL produce product 0 regardless of sign (no negative zero issue in two's complement).
REQ-021 start in RUN or FINISH SHALL be ignored; operands and accumulator are not disturbed.
REQ-022 A new start SHALL be accepted no earlier than the edge after done (first IDLE cycle); back-to-back throughput is one product per WORDLENGTH+2 cycles.
REQ-023 product SHALL hold its last value between done pulses, including while busy.
REQ-024 Operand inputs SHALL be don't-care except at the accepting edge.

Reset
REQ-025 While reset=0: state=IDLE, busy=0, done=0, product=0, counter=0, accumulator=0.
REQ-026 Reset asserted mid-RUN or mid-FINISH SHALL abort the operation with no done pulse and product=0.
REQ-027 start sampled on the first edge after reset release SHALL be accepted normally.

Structure
REQ-028 Shared package SHALL hold WORDLENGTH and FRACBITS defaults, state encodings (IDLE, RUN, FINISH), and Q-format saturation constants MAXPOS/MAXNEG.
REQ-029 Rounding and saturation SHALL be a combinational sub-module round_sat (input: sign, 2*WORDLENGTH+1-bit magnitude; output: WORDLENGTH-bit product) instantiated once.
REQ-030 Datapath SHALL use one adder of width 2*WORDLENGTH+1; no hardware multiplier inferred.

Verification
REQ-031 A=0x4000, B=0x4000, start at edge 0 -> busy=1 edges 1..17, done at edge 17, product=0x2000.
REQ-032 A=0x8000, B=0x8000 -> product=0x7FFF (saturated); A=0x8000, B=0x7FFF -> product=0x8001.
REQ-033 A=0x0001, B=0x4000 -> product=0x0001; A=0xFFFF, B=0x4000 -> product=0xFFFF (half away from zero).
REQ-034 A=0x4000, B=0x4000 started; start pulsed at edges 5 and 17 with A=B=0x7FFF -> ignored, single done, product=0x2000; start at edge 18 accepted.
REQ-035 Reset driven low at edge 8 of an operation -> busy, done and product 0 immediately; no done after release.
REQ-036 1000 random operand pairs compared against reference model (round-half-away, saturate) -> exact match, latency 17 every time.
